// File: rtl/unary_serializer.sv
// unary_serializer: expands a binary count into an N_BITS serial thermometer stream.
// UNARY_SERIALIZER_SATURATE_EN clamps out-of-range counts to N_BITS instead of dropping them with an err pulse.
module unary_serializer #(
    parameter int N_BITS = 8,
    parameter int CW     = $clog2(N_BITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bit,
    output logic          out_last,
    output logic          err
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nx;
    logic [CW-1:0] idx, cnt, load;
    logic accept, over, take;
    assign accept    = in_valid && in_ready;
    assign over      = in_count > CW'(N_BITS);
    assign in_ready  = state == IDLE;
    assign out_valid = state == SHIFT;
    assign out_bit   = out_valid && idx < cnt;
    assign out_last  = out_valid && idx == CW'(N_BITS - 1);
`ifdef UNARY_SERIALIZER_SATURATE_EN
    assign take = accept;
    assign load = over ? CW'(N_BITS) : in_count;
    assign err  = 1'b0;
`else
    logic err_q;
    assign take = accept && !over;
    assign load = in_count;
    assign err  = err_q;
    // an out-of-range count is consumed without leaving IDLE; flag it for one cycle
    always_ff @(posedge clk)
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= accept && over;
`endif
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = take ? SHIFT : IDLE;
        else               state_nx = (out_ready && out_last) ? IDLE : SHIFT;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                cnt <= load;
                idx <= '0;
            end else if (out_valid && out_ready && !out_last) begin
                idx <= idx + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_unary_serializer.sv
// tb_unary_serializer: directed checks of the thermometer serializer (default N_BITS=8).
module tb_unary_serializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_count = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_bit;
    logic       out_last;
    logic       err;
    int         errors = 0;
    int         checks = 0;

    unary_serializer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_count(in_count), .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] k);
        chk("send_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_count = k;
        step;
        in_valid = 1'b0;
    endtask

    // exp[i] is the i-th emitted bit; stall[i] holds out_ready low for two cycles before bit i is taken
    task automatic recv(input string tag, input logic [7:0] exp, input logic [7:0] stall, input logic noise);
        for (int i = 0; i < 8; i++) begin
            if (stall[i]) begin
                for (int s = 0; s < 2; s++) begin
                    out_ready = 1'b0;
                    chk({tag, "_stall_valid"}, out_valid, 1'b1);
                    chk({tag, "_stall_bit"}, out_bit, exp[i]);
                    chk({tag, "_stall_last"}, out_last, i == 7);
                    step;
                end
            end
            out_ready = 1'b1;
            if (noise) begin
                in_valid = 1'b1;
                in_count = 4'(i);
            end
            chk({tag, "_valid"}, out_valid, 1'b1);
            chk({tag, "_in_ready"}, in_ready, 1'b0);
            chk({tag, "_bit"}, out_bit, exp[i]);
            chk({tag, "_last"}, out_last, i == 7);
            chk({tag, "_err"}, err, 1'b0);
            step;
        end
        in_valid = 1'b0;
        chk({tag, "_end_in_ready"}, in_ready, 1'b1);
        chk({tag, "_end_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        step;
        step;
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bit", out_bit, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_err", err, 1'b0);

        send(4'd3);
        recv("k3", 8'b0000_0111, 8'h00, 1'b0);

        send(4'd0);
        recv("k0", 8'b0000_0000, 8'h00, 1'b0);
        send(4'd8);
        recv("k8", 8'b1111_1111, 8'h00, 1'b1);

        send(4'd5);
        recv("k5_stall", 8'b0001_1111, 8'b1010_1010, 1'b0);

        send(4'd6);
        for (int i = 0; i < 4; i++) begin
            chk("k6_bit", out_bit, 1'b1);
            step;
        end
        chk("k6_pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        step;
        chk("abort_stays_idle", out_valid, 1'b0);
        send(4'd2);
        recv("k2", 8'b0000_0011, 8'h00, 1'b0);

`ifdef UNARY_SERIALIZER_SATURATE_EN
        send(4'd12);
        recv("k12_sat", 8'b1111_1111, 8'h00, 1'b0);
        chk("k12_sat_err", err, 1'b0);
`else
        send(4'd12);
        chk("k12_err", err, 1'b1);
        chk("k12_valid", out_valid, 1'b0);
        chk("k12_in_ready", in_ready, 1'b1);
        step;
        chk("k12_err_off", err, 1'b0);
        chk("k12_valid_off", out_valid, 1'b0);
        send(4'd1);
        recv("k1", 8'b0000_0001, 8'h00, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
